spi_frame_slave: RTL and testbench
==================================

# spi_frame_slave

SPI mode-0 slave front end for the board-control register space. Converts an SPI frame into a register address, a received data byte and a write strobe. It also shifts the read byte back to the host, supplied by the downstream combinational read-data selector from the current address. It sits between the external SPI pins and the register read/write logic, in the system `clk` domain.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronisers on `spi_sclk`, `spi_cs_n` and `spi_mosi`; minimum 2.
- `ADDR_FILL`, 8'h00: byte driven on MISO while the address byte is being received.
- `clk` in 1: system clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_sclk` in 1: SPI clock, asynchronous to `clk`, idle low; frequency ≤ `clk`/8.
- `spi_cs_n` in 1: SPI chip select, active low, asynchronous.
- `spi_mosi` in 1: SPI serial data in, MSB first.
- `spi_miso` out 1: SPI serial data out, MSB first.
- `spi_miso_oe` out 1: MISO output enable; 1 while the frame is active.
- `addr` out 8: current register address; drives the read-data selector.
- `mosi` out 8: last complete data byte received.
- `wr_stb` out 1: one-`clk` pulse; `addr`/`mosi` form a valid write.
- `data` in 8: read byte for `addr`, combinational from the selector.
- `busy` out 1: frame in progress (state ≠ IDLE).

## Operation
- Synchronise the three SPI inputs through `SYNC_STAGES` flops. Detect SCLK rise/fall and CS_n fall/rise on the synchronised signals.
- State machine:
  - IDLE: wait for a CS_n fall; then clear the bit counter, load the tx shifter with `ADDR_FILL` and go to ADDR.
  - ADDR: shift in `spi_mosi` on each SCLK rise. On the 8th rise, `addr` <= received byte and go to DATA.
  - DATA: shift in on each SCLK rise. On the 8th rise, `mosi` <= received byte and `wr_stb` = 1 for the next `clk`. `addr` increments by 1 one `clk` after the `wr_stb` pulse; 8'hFF wraps to 8'h00. Remain in DATA for burst bytes.
- Any state, CS_n rise: return to IDLE. A partial byte is discarded with no `wr_stb` and no `addr` update. `spi_miso_oe` <= 0.
- TX shifter:
  - Shift left on each SCLK fall; `spi_miso` = shifter MSB.
  - Reload with `data` 2 `clk` after every `addr` update: the initial load after ADDR and each increment in DATA. The MSB is thus valid before the first SCLK fall of the byte, so the host samples it on the following rise.
- The bit counter is 3 bits and wraps 7→0 at each byte boundary.
- Simultaneous CS_n rise and 8th SCLK rise in the same `clk` (after sync): CS_n wins; the byte is discarded.
- Every read is also a write: the DATA byte is always strobed. The register decode ignores `wr_stb` for read-only addresses; this block does not filter.

## Timing
- Reset values:
  - `addr`=8'h00, `mosi`=8'h00, `wr_stb`=0, `busy`=0.
  - `spi_miso`=0, `spi_miso_oe`=0, state IDLE.
  - Synchronisers cleared, with CS_n flops reset to 1.
- Input latency: an SPI edge takes effect `SYNC_STAGES`+1 `clk` after it reaches the pin.
- `busy` goes high 1 `clk` after the synchronised CS_n fall.
- `addr` is valid 1 `clk` after the synchronised 8th SCLK rise of the address byte.
- The tx load follows the `addr` update by 2 `clk`.
- `wr_stb` asserts 1 `clk` after the synchronised 8th rise of a data byte. `addr` and `mosi` are stable during `wr_stb`; `addr` changes on the following `clk`.
- The `clk`/8 minimum ratio guarantees the load completes within half an SCLK period.
- `rst_n` low mid-frame forces the reset values immediately. After release, the block stays in IDLE until a fresh CS_n fall; an already-low CS_n is ignored.

## Test plan
- Single write:
  - Stimulus: CS low, send 8'h23 then 8'h5A, CS high.
  - Required: one `wr_stb` with `addr`=8'h23, `mosi`=8'h5A; `addr` then becomes 8'h24; `busy` falls.
- Read:
  - Stimulus: model the selector with `data`=8'h11 at `addr` 8'h00; send 8'h00, 8'hFF.
  - Required: MISO returns 8'h00 (fill) then 8'h11.
- Burst with wrap:
  - Stimulus: address 8'hFE, then data 8'h01, 8'h02, 8'h03.
  - Required: strobes at 8'hFE, 8'hFF, 8'h00 carrying 8'h01, 8'h02, 8'h03.
- Abort:
  - Stimulus: address 8'h30, then CS high after 5 data bits.
  - Required: no `wr_stb`; `addr` stays 8'h30; `spi_miso_oe`=0.
- Reset mid-frame:
  - Stimulus: pull `rst_n` low during a data byte.
  - Required: all outputs at reset values; no strobe until a new CS_n fall.
- Speed limit:
  - Stimulus: SCLK = `clk`/8, 4-byte burst.
  - Required: every MISO bit matches the selector model; no missed edges.

Source files
------------

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave front end: turns an SPI frame (address byte, then burst data bytes) into
// register address / write-data / strobe, and shifts the selected read byte back on MISO.
module spi_frame_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ADDR_FILL   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] addr,
  output logic [7:0] mosi,
  output logic       wr_stb,
  input  logic [7:0] data,
  output logic       busy
);

  localparam int unsigned SettleW = $clog2(SYNC_STAGES + 1) + 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [SettleW-1:0] settle_q;
  logic               settled, armed_q;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d, rx_byte;
  logic [7:0] addr_q, addr_d;
  logic [7:0] mosi_q, mosi_d;
  logic       wr_stb_q, wr_stb_d;
  logic [7:0] tx_q, tx_d;
  logic       oe_q, oe_d;
  logic [1:0] ld_q, ld_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  // A CS_n already low when reset releases must not look like a fresh frame start.
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;

  assign settled = (settle_q == SettleW'(SYNC_STAGES));
  assign rx_byte = {rx_q[6:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    addr_d    = addr_q;
    mosi_d    = mosi_q;
    wr_stb_d  = 1'b0;
    tx_d      = tx_q;
    oe_d      = oe_q;
    ld_d      = {ld_q[0], 1'b0};

    // Post-write address advance; the read byte for the new address loads two clk later.
    if (wr_stb_q) begin
      addr_d  = addr_q + 8'd1;
      ld_d[0] = 1'b1;
    end
    if (ld_q[1]) begin
      tx_d = data;
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d   = StAddr;
          bit_cnt_d = 3'd0;
          tx_d      = ADDR_FILL;
          oe_d      = 1'b1;
          ld_d      = 2'b00;
        end
      end
      StAddr, StData: begin
        if (cs_rise) begin
          state_d = StIdle;
          oe_d    = 1'b0;
          ld_d    = 2'b00;
        end else if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          rx_d      = rx_byte;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == StAddr) begin
              addr_d  = rx_byte;
              ld_d[0] = 1'b1;
              state_d = StData;
            end else begin
              mosi_d   = rx_byte;
              wr_stb_d = 1'b1;
            end
          end
        end else if (sclk_fall && bit_cnt_q != 3'd0) begin
          // The fall right after a byte boundary keeps the freshly loaded MSB on the pin.
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      addr_q      <= 8'h00;
      mosi_q      <= 8'h00;
      wr_stb_q    <= 1'b0;
      tx_q        <= 8'h00;
      oe_q        <= 1'b0;
      ld_q        <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      if (!settled) begin
        settle_q <= settle_q + 1'b1;
      end
      armed_q     <= armed_q | (settled & cs_s);
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      mosi_q      <= mosi_d;
      wr_stb_q    <= wr_stb_d;
      tx_q        <= tx_d;
      oe_q        <= oe_d;
      ld_q        <= ld_d;
    end
  end

  assign spi_miso    = tx_q[7];
  assign spi_miso_oe = oe_q;
  assign addr        = addr_q;
  assign mosi        = mosi_q;
  assign wr_stb      = wr_stb_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_spi_frame_slave.sv
// Randomised bench for spi_frame_slave: a host drives SPI frames, a selector memory supplies
// read data, and expected strobes / MISO bits come from a frame-level model.
module tb_spi_frame_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, wr_stb, busy;
  logic [7:0] addr, mosi, data;

  logic [7:0] sel_mem [256];
  logic [7:0] exp_a [$];
  logic [7:0] exp_d [$];
  logic [7:0] f_mosi [16];
  logic [7:0] f_miso [16];
  logic [7:0] inc_exp;
  bit         inc_pend = 1'b0;
  int         checks = 0;
  int         errors = 0;

  assign data = sel_mem[addr];

  spi_frame_slave #(.SYNC_STAGES(2), .ADDR_FILL(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .addr        (addr),
    .mosi        (mosi),
    .wr_stb      (wr_stb),
    .data        (data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every strobe must match the next modelled write; the address advances one clk later.
  always @(negedge clk) begin
    if (!rst_n) begin
      inc_pend = 1'b0;
    end else begin
      if (inc_pend) begin
        check("addr_inc", addr, inc_exp);
        inc_pend = 1'b0;
      end
      if (wr_stb) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stb: got strobe addr %h data %h expected none", addr, mosi);
        end else begin
          logic [7:0] ea, ed;
          ea = exp_a.pop_front();
          ed = exp_d.pop_front();
          check("stb_addr", addr, ea);
          check("stb_data", mosi, ed);
          inc_exp  = ea + 8'd1;
          inc_pend = 1'b1;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input int half, input logic exp, input bit chk,
                          input bit cs_up);
    spi_mosi = b;
    repeat (half) @(negedge clk);
    if (chk) check("miso_bit", {7'b0, spi_miso}, {7'b0, exp});
    spi_sclk = 1'b1;
    if (cs_up) spi_cs_n = 1'b1;
    repeat (half) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  // Drives f_mosi[0..nbytes-1]; the last byte is cut to last_bits bits.
  task automatic host_frame(input int nbytes, input int half, input int last_bits,
                            input bit cs_with_rise);
    int bits;
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_in_frame", {7'b0, busy}, 8'h01);
    check("oe_in_frame", {7'b0, spi_miso_oe}, 8'h01);
    for (int k = 0; k < nbytes; k++) begin
      bits = (k == nbytes - 1) ? last_bits : 8;
      for (int i = 7; i >= 8 - bits; i--) begin
        send_bit(f_mosi[k][i], half, f_miso[k][i], 1'b1,
                 cs_with_rise && (k == nbytes - 1) && (i == 8 - bits));
      end
    end
    repeat (half) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_after", {7'b0, busy}, 8'h00);
    check("oe_after", {7'b0, spi_miso_oe}, 8'h00);
    check("stb_left", 8'(exp_a.size()), 8'h00);
  endtask

  // Model: byte 0 returns the fill, byte k returns sel_mem[a+k-1] and strobes a write there.
  task automatic model_frame(input logic [7:0] a, input int ndata);
    logic [7:0] d;
    f_mosi[0] = a;
    f_miso[0] = 8'h00;
    for (int k = 1; k <= ndata; k++) begin
      d = 8'($urandom);
      f_mosi[k] = d;
      f_miso[k] = sel_mem[8'(a + 8'(k - 1))];
      exp_a.push_back(8'(a + 8'(k - 1)));
      exp_d.push_back(d);
    end
  endtask

  initial begin
    logic [7:0] a;
    int         n;
    for (int i = 0; i < 256; i++) sel_mem[i] = 8'($urandom);
    sel_mem[0] = 8'h11;
    repeat (3) @(negedge clk);
    #1;
    check("rst_addr", addr, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_oe", {7'b0, spi_miso_oe}, 8'h00);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Single write 0x23 <- 0x5A
    f_mosi[0] = 8'h23; f_miso[0] = 8'h00;
    f_mosi[1] = 8'h5A; f_miso[1] = sel_mem[8'h23];
    exp_a.push_back(8'h23); exp_d.push_back(8'h5A);
    host_frame(2, 5, 8, 1'b0);
    check("single_addr_after", addr, 8'h24);

    // Read from 0x00: fill then selector byte 0x11
    f_mosi[0] = 8'h00; f_miso[0] = 8'h00;
    f_mosi[1] = 8'hFF; f_miso[1] = 8'h11;
    exp_a.push_back(8'h00); exp_d.push_back(8'hFF);
    host_frame(2, 4, 8, 1'b0);

    // Burst wrapping through 0xFF
    f_mosi[0] = 8'hFE; f_miso[0] = 8'h00;
    f_mosi[1] = 8'h01; f_miso[1] = sel_mem[8'hFE];
    f_mosi[2] = 8'h02; f_miso[2] = sel_mem[8'hFF];
    f_mosi[3] = 8'h03; f_miso[3] = sel_mem[8'h00];
    exp_a.push_back(8'hFE); exp_d.push_back(8'h01);
    exp_a.push_back(8'hFF); exp_d.push_back(8'h02);
    exp_a.push_back(8'h00); exp_d.push_back(8'h03);
    host_frame(4, 6, 8, 1'b0);
    check("burst_addr_after", addr, 8'h01);

    // Abort after 5 data bits
    f_mosi[0] = 8'h30; f_miso[0] = 8'h00;
    f_mosi[1] = 8'hA5; f_miso[1] = sel_mem[8'h30];
    host_frame(2, 5, 5, 1'b0);
    check("abort_addr", addr, 8'h30);

    // CS_n rise coincident with the 8th data rise: byte discarded
    f_mosi[0] = 8'h40; f_miso[0] = 8'h00;
    f_mosi[1] = 8'hC3; f_miso[1] = sel_mem[8'h40];
    host_frame(2, 5, 8, 1'b1);
    check("cs_wins_addr", addr, 8'h40);

    // Reset in the middle of a data byte, CS_n left low through the release
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 7; i >= 0; i--) send_bit(a[0] ^ i[0], 5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 5, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_addr", addr, 8'h00);
    check("mrst_mosi", mosi, 8'h00);
    check("mrst_stb", {7'b0, wr_stb}, 8'h00);
    check("mrst_busy", {7'b0, busy}, 8'h00);
    check("mrst_miso", {7'b0, spi_miso}, 8'h00);
    check("mrst_oe", {7'b0, spi_miso_oe}, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) send_bit(1'b1, 4, 1'b0, 1'b0, 1'b0);
    check("mrst_idle_busy", {7'b0, busy}, 8'h00);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);

    // Speed limit: 4-byte burst at clk/8
    a = 8'($urandom);
    model_frame(a, 4);
    host_frame(5, 4, 8, 1'b0);
    check("speed_addr_after", addr, 8'(a + 8'd4));

    // Random frames
    for (int r = 0; r < 8; r++) begin
      a = 8'($urandom);
      n = 1 + int'($urandom_range(0, 4));
      model_frame(a, n);
      host_frame(n + 1, int'($urandom_range(4, 7)), 8, 1'b0);
      check("rand_addr_after", addr, 8'(a + 8'(n)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
